width_div_arbiter: RTL and testbench
====================================

# width_div_arbiter

Packet-granular round-robin arbiter that shares one 256-bit AXI4-Stream `width_divider` (256→64) between `NUM_PORTS` 256-bit sources in the 10G input path. It grants one source at a time and holds the grant until that packet's `tlast` beat is accepted. Beats are forwarded through one output register stage that feeds the divider's `s_axis_*` side directly. Grant state is exposed for debug and statistics.

## Interface
- `NUM_PORTS`, 4: number of requesting sources, 2..8.
- `DATA_WIDTH`, 256: tdata width; tkeep width is `DATA_WIDTH/8`.
- `USER_WIDTH`, 1: tuser width per beat.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  NUM_PORTS*DATA_WIDTH  per-port data; port i occupies slice i.
- `s_axis_tkeep`  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables.
- `s_axis_tuser`  in  NUM_PORTS*USER_WIDTH  per-port sideband.
- `s_axis_tlast`  in  NUM_PORTS  per-port end of packet.
- `s_axis_tvalid`  in  NUM_PORTS  per-port valid; also acts as the request.
- `s_axis_tready`  out  NUM_PORTS  per-port ready; one-hot or zero.
- `m_axis_tdata`  out  DATA_WIDTH  to the divider.
- `m_axis_tkeep`  out  DATA_WIDTH/8.
- `m_axis_tuser`  out  USER_WIDTH.
- `m_axis_tlast`  out  1.
- `m_axis_tvalid`  out  1.
- `m_axis_tready`  in  1  from the divider.
- `grant`  out  clog2(NUM_PORTS)  index of the current or most recent owner.
- `busy`  out  1  high while a packet is locked.

## Operation
- FSM has two states, IDLE and LOCK.
- IDLE: if any `s_axis_tvalid` is high, select the first valid port at or after `rr_ptr`, searching upward with wrap. Register it into `grant` and go to LOCK. If no port is valid, stay in IDLE.
- LOCK: `s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready`. All other ready bits are 0.
- Accepted beat (valid && ready on the granted port): copy data, keep, user and last into the output register and set `m_axis_tvalid`.
- If the output register drains with no new beat accepted, clear `m_axis_tvalid`.
- Accepted beat with tlast = 1: go to IDLE and set `rr_ptr = grant+1`, wrapping modulo `NUM_PORTS`.
- Beats pass unmodified. tkeep is not checked or modified. A beat with tkeep = 0 still forwards.
- Requests from non-granted ports are ignored until the granted packet ends. A request is never dropped.
- A granted port that deasserts tvalid mid-packet keeps the lock indefinitely. There is no timeout.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `grant`=0, `busy`=0, `m_axis_tvalid`=0, all `s_axis_tready`=0. `m_axis_tdata`, `tkeep`, `tuser` and `tlast` reset to 0.
- Arbitration takes 1 cycle. A request seen in IDLE at edge N gives LOCK and ready at cycle N+1.
- Forward latency is 1 cycle: a beat accepted at edge K is visible on `m_axis_*` after edge K.
- Throughput is 1 beat/cycle within a packet while `m_axis_tready`=1.
- There is exactly one IDLE cycle between packets, so back-to-back packets cost 1 bubble.
- Single-beat packet (tlast on the first beat): LOCK for 1 cycle, then IDLE.
- Backpressure: with `m_axis_tready`=0 and the output register full, all readies are 0. Output data stays stable until accepted (AXI rule).
- Requests that arrive in IDLE in the same cycle compete by round-robin only; lower index does not win by default.
- `resetn` asserted mid-packet: immediate return to reset values. Any partially sent packet is truncated, and the divider must also be reset.

## Structure
- Shared package `nf10_upb_axis_pkg`: the `NUM_PORTS` limit constant and the state encoding (`ST_IDLE`, `ST_LOCK`).
- One sub-module, `rr_select`: purely combinational. Inputs are the request vector and `rr_ptr`; outputs are the chosen index and `any`. It is reusable by other arbiters.
- No divider logic is inside this block. It instantiates nothing from the datapath.

## Test plan
- Single port: port 0 sends a 3-beat packet of data {2{128'hDEADBEEFDEADBEEFAFFEDEADAFFEDEAD}}, keep 32'hFFFFFFFF, with `m_axis_tready`=1. Required: 3 output beats, tlast on the 3rd, `grant`=0, then IDLE.
- Fairness: all 4 ports hold 2-beat packets continuously. Required: grant order 0,1,2,3,0, with exactly 1 bubble between packets.
- No interleave: port 2 is granted, then port 1 raises valid mid-packet. Required: port 1 gets no ready until port 2's tlast is accepted. Next grant is port 3 if it is valid, else port 1.
- Backpressure: hold `m_axis_tready` low for 5 cycles mid-packet. Required: output held stable, `s_axis_tready` low, no beat lost or duplicated.
- Source stall: granted port 1 drops tvalid for 10 cycles mid-packet while port 0 is valid. Required: lock held on port 1 and port 0 not granted.
- Reset: assert `resetn`=0 mid-packet. Required: all outputs at reset values in the same cycle. After release, port 0 wins first if it is valid.

Source files
------------

// File: rtl/nf10_upb_axis_pkg.sv
// Shared AXI-Stream arbitration constants: port-count limit and the
// two-state lock FSM encoding used by the packet arbiters.
package nf10_upb_axis_pkg;

   localparam int MAX_PORTS = 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first asserted request at or after
// i_ptr, searching upward with wrap.
module rr_select #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   int w_pos;

   // Walk offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      o_idx = i_ptr;
      o_any = |i_req;
      w_pos = 0;
      for (int k = N - 1; k >= 0; k--) begin
         w_pos = (int'(i_ptr) + k) % N;
         if (i_req[w_pos]) o_idx = IW'(w_pos);
      end
   end

endmodule

// File: rtl/width_div_arbiter.sv
// Packet-granular round-robin arbiter sharing one 256->64 width divider
// between NUM_PORTS sources, with a single output register stage.
module width_div_arbiter
   import nf10_upb_axis_pkg::*;
#(
   parameter  int NUM_PORTS  = 4,
   parameter  int DATA_WIDTH = 256,
   parameter  int USER_WIDTH = 1,
   localparam int GW         = $clog2(NUM_PORTS),
   localparam int KW         = DATA_WIDTH / 8
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [NUM_PORTS*KW-1:0]          s_axis_tkeep,
   input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_axis_tuser,
   input  logic [NUM_PORTS-1:0]             s_axis_tlast,
   input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
   output logic [NUM_PORTS-1:0]             s_axis_tready,
   output logic [DATA_WIDTH-1:0]            m_axis_tdata,
   output logic [KW-1:0]                    m_axis_tkeep,
   output logic [USER_WIDTH-1:0]            m_axis_tuser,
   output logic                             m_axis_tlast,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic [GW-1:0]                    grant,
   output logic                             busy
);

   logic [0:0]            r_state;
   logic [GW-1:0]         r_ptr;
   logic [GW-1:0]         r_grant;
   logic                  r_mvalid;
   logic [DATA_WIDTH-1:0] r_mdata;
   logic [KW-1:0]         r_mkeep;
   logic [USER_WIDTH-1:0] r_muser;
   logic                  r_mlast;

   logic [GW-1:0]         w_sel;
   logic                  w_any;
   logic                  w_free;
   logic                  w_acc;
   logic [DATA_WIDTH-1:0] w_data;
   logic [KW-1:0]         w_keep;
   logic [USER_WIDTH-1:0] w_user;
   logic                  w_last;

   rr_select #(.N(NUM_PORTS), .IW(GW)) u_rr (
      .i_req (s_axis_tvalid),
      .i_ptr (r_ptr),
      .o_idx (w_sel),
      .o_any (w_any)
   );

   // Output slot can take a beat when empty or draining this cycle.
   assign w_free = !r_mvalid || m_axis_tready;

   always_comb begin
      w_data = s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
      w_keep = s_axis_tkeep[r_grant*KW +: KW];
      w_user = s_axis_tuser[r_grant*USER_WIDTH +: USER_WIDTH];
      w_last = s_axis_tlast[r_grant];
   end

   always_comb begin
      s_axis_tready = '0;
      if (r_state == ST_LOCK && w_free) s_axis_tready[r_grant] = 1'b1;
   end

   assign w_acc = (r_state == ST_LOCK) && w_free && s_axis_tvalid[r_grant];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_grant <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_grant <= w_sel;
                  r_state <= ST_LOCK;
               end
            end
            default: begin
               if (w_acc && w_last) begin
                  r_state <= ST_IDLE;
                  r_ptr   <= (r_grant == GW'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mvalid <= 1'b0;
         r_mdata  <= '0;
         r_mkeep  <= '0;
         r_muser  <= '0;
         r_mlast  <= 1'b0;
      end else if (w_acc) begin
         r_mvalid <= 1'b1;
         r_mdata  <= w_data;
         r_mkeep  <= w_keep;
         r_muser  <= w_user;
         r_mlast  <= w_last;
      end else if (m_axis_tready) begin
         r_mvalid <= 1'b0;
      end
   end

   assign m_axis_tdata  = r_mdata;
   assign m_axis_tkeep  = r_mkeep;
   assign m_axis_tuser  = r_muser;
   assign m_axis_tlast  = r_mlast;
   assign m_axis_tvalid = r_mvalid;
   assign grant         = r_grant;
   assign busy          = (r_state == ST_LOCK);

endmodule

// File: tb/tb_width_div_arbiter.sv
// Bench for width_div_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based transaction model.
module tb_width_div_arbiter;

   localparam int N  = 4;
   localparam int DW = 256;
   localparam int KW = DW / 8;
   localparam int UW = 1;
   localparam int GW = 2;

   logic            clk = 1'b0;
   logic            resetn = 1'b1;
   logic [N*DW-1:0] s_tdata  = '0;
   logic [N*KW-1:0] s_tkeep  = '0;
   logic [N*UW-1:0] s_tuser  = '0;
   logic [N-1:0]    s_tlast  = '0;
   logic [N-1:0]    s_tvalid = '0;
   logic [N-1:0]    s_tready;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic [UW-1:0]   m_tuser;
   logic            m_tlast;
   logic            m_tvalid;
   logic            m_tready = 1'b0;
   logic [GW-1:0]   grant;
   logic            busy;

   width_div_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tuser  (s_tuser),
      .s_axis_tlast  (s_tlast),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tuser  (m_tuser),
      .m_axis_tlast  (m_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .grant         (grant),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      logic          l;
   } beat_t;

   beat_t srcq [N][$];
   beat_t outq [$];
   bit    drv_v [N];
   int    vp [N];
   int    rp = 100;
   int    mr_force = -1;
   bit    auto_gen = 0;
   int    owner = -1, rr_ptr = 0, last_grant = 0;
   int    out_beats = 0;
   int    acc_cnt [N];
   int    glog [$];
   bit    prev_busy = 0;
   int    cyc = 0, first_mv = -1, last_mv = -1;
   int    n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_pkt(input int p, input int len, input bit fixed);
      beat_t b;
      logic [DW-1:0] pat;
      pat = {2{128'hDEADBEEFDEADBEEFAFFEDEADAFFEDEAD}};
      for (int i = 0; i < len; i++) begin
         if (fixed) begin
            b.d = pat;
            b.k = '1;
         end else begin
            for (int j = 0; j < DW / 32; j++) b.d[j*32 +: 32] = $urandom;
            b.k = $urandom;
         end
         b.u = UW'($urandom_range(1));
         b.l = (i == len - 1);
         srcq[p].push_back(b);
      end
   endtask

   function automatic bit pending();
      bit r;
      r = (owner >= 0) || (outq.size() > 0);
      for (int p = 0; p < N; p++) if (srcq[p].size() > 0) r = 1;
      return r;
   endfunction

   task automatic drive();
      for (int p = 0; p < N; p++) begin
         if (!drv_v[p] && srcq[p].size() > 0 && int'($urandom_range(99)) < vp[p]) drv_v[p] = 1;
         s_tvalid[p] = drv_v[p];
         if (drv_v[p]) begin
            s_tdata[p*DW +: DW] = srcq[p][0].d;
            s_tkeep[p*KW +: KW] = srcq[p][0].k;
            s_tuser[p*UW +: UW] = srcq[p][0].u;
            s_tlast[p]          = srcq[p][0].l;
         end else begin
            s_tdata[p*DW +: DW] = '0;
            s_tkeep[p*KW +: KW] = '0;
            s_tuser[p*UW +: UW] = '0;
            s_tlast[p]          = 1'b0;
         end
      end
      m_tready = (mr_force >= 0) ? mr_force[0] : (int'($urandom_range(99)) < rp);
   endtask

   // One clock: drive at negedge, check model vs DUT, advance the model.
   task automatic cycle();
      logic [N-1:0] er;
      int acc, pos;
      beat_t hb;
      if (auto_gen)
         for (int p = 0; p < N; p++)
            if (srcq[p].size() == 0 && $urandom_range(7) == 0) push_pkt(p, int'($urandom_range(1, 5)), 0);
      drive();
      #1;
      er = '0;
      if (owner >= 0 && (outq.size() == 0 || m_tready)) er[owner] = 1'b1;
      chk("s_tready", s_tready, er);
      chk("m_tvalid", m_tvalid, outq.size() > 0);
      chk("busy", busy, owner >= 0);
      chk("grant", grant, last_grant);
      if (outq.size() > 0) begin
         chk("m_tdata", m_tdata, outq[0].d);
         chk("m_tkeep", m_tkeep, outq[0].k);
         chk("m_tuser", m_tuser, outq[0].u);
         chk("m_tlast", m_tlast, outq[0].l);
      end
      if (busy && !prev_busy) glog.push_back(int'(grant));
      prev_busy = busy;
      if (m_tvalid) begin
         if (first_mv < 0) first_mv = cyc;
         last_mv = cyc;
      end
      acc = (owner >= 0 && er[owner] && drv_v[owner]) ? owner : -1;
      if (outq.size() > 0 && m_tready) begin
         void'(outq.pop_front());
         out_beats++;
      end
      if (owner < 0) begin
         for (int k = 0; k < N; k++) begin
            pos = (rr_ptr + k) % N;
            if (drv_v[pos]) begin
               owner = pos;
               last_grant = pos;
               break;
            end
         end
      end else if (acc >= 0) begin
         hb = srcq[acc].pop_front();
         outq.push_back(hb);
         drv_v[acc] = 0;
         acc_cnt[acc]++;
         if (hb.l) begin
            rr_ptr = (owner + 1) % N;
            owner = -1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #1;
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tkeep", m_tkeep, 0);
      chk("rst_m_tuser", m_tuser, 0);
      chk("rst_m_tlast", m_tlast, 0);
      owner = -1; rr_ptr = 0; last_grant = 0; prev_busy = 0;
      outq.delete();
      for (int p = 0; p < N; p++) begin
         srcq[p].delete();
         drv_v[p] = 0;
      end
      s_tvalid = '0;
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      for (int p = 0; p < N; p++) vp[p] = 100;
      rp = 100;
      mr_force = -1;
      while (pending() && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_in_budget", n < budget, 1);
   endtask

   initial begin
      int exp_fair [5];
      int a0, n;
      exp_fair = '{0, 1, 2, 3, 0};
      for (int p = 0; p < N; p++) begin
         vp[p] = 100;
         acc_cnt[p] = 0;
         drv_v[p] = 0;
      end
      @(negedge clk);
      do_reset();
      cycle();

      // Fairness: all ports busy, expect 0,1,2,3,0 with one bubble each.
      glog.delete(); first_mv = -1; out_beats = 0;
      push_pkt(0, 2, 0); push_pkt(0, 2, 0);
      push_pkt(1, 2, 0); push_pkt(2, 2, 0); push_pkt(3, 2, 0);
      drain(200);
      chk("fair_count", glog.size(), 5);
      for (int i = 0; i < 5; i++) chk("fair_order", glog[i], exp_fair[i]);
      chk("fair_span", last_mv - first_mv + 1, 14);
      chk("fair_beats", out_beats, 10);

      // Single port, fixed pattern, 3 beats.
      glog.delete(); out_beats = 0;
      push_pkt(0, 3, 1);
      drain(50);
      chk("single_beats", out_beats, 3);
      chk("single_grant", glog[0], 0);
      chk("single_idle", busy, 0);

      // No interleave: port 1 waits behind port 2; then port 3 beats port 1.
      glog.delete();
      push_pkt(2, 4, 0);
      repeat (3) cycle();
      push_pkt(1, 2, 0);
      drain(50);
      chk("nointl_n", glog.size(), 2);
      chk("nointl_first", glog[0], 2);
      chk("nointl_next", glog[1], 1);
      glog.delete();
      push_pkt(2, 3, 0);
      repeat (2) cycle();
      push_pkt(1, 2, 0);
      push_pkt(3, 2, 0);
      drain(50);
      chk("nointl3_next", glog[1], 3);
      chk("nointl3_last", glog[2], 1);

      // Backpressure mid-packet.
      out_beats = 0;
      push_pkt(0, 4, 0);
      repeat (3) cycle();
      mr_force = 0;
      repeat (5) cycle();
      mr_force = -1;
      drain(50);
      chk("bp_beats", out_beats, 4);

      // Source stall on granted port 1 while port 0 requests.
      glog.delete();
      a0 = acc_cnt[1];
      push_pkt(1, 3, 0);
      n = 0;
      while (acc_cnt[1] == a0 && n < 20) begin
         cycle();
         n++;
      end
      chk("stall_first_beat", n < 20, 1);
      vp[1] = 0;
      push_pkt(0, 2, 0);
      repeat (10) begin
         cycle();
         chk("stall_busy", busy, 1);
         chk("stall_grant", grant, 1);
      end
      drain(50);
      chk("stall_order0", glog[0], 1);
      chk("stall_order1", glog[1], 0);

      // Reset mid-packet, then port 0 wins first.
      push_pkt(0, 4, 0);
      push_pkt(2, 4, 0);
      repeat (3) cycle();
      do_reset();
      glog.delete();
      push_pkt(0, 2, 0);
      push_pkt(2, 2, 0);
      drain(50);
      chk("post_rst_first", glog[0], 0);
      chk("post_rst_second", glog[1], 2);

      // Random traffic with random stalls and backpressure.
      auto_gen = 1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 100 == 0) begin
            for (int p = 0; p < N; p++) vp[p] = int'($urandom_range(20, 100));
            rp = int'($urandom_range(30, 100));
         end
         cycle();
      end
      auto_gen = 0;
      drain(500);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
